lcd_spi_monitor: RTL and testbench
==================================

# lcd_spi_monitor

Passive receiver for the panel-side end of the 4-wire LCD write bus (`lcd_cs`, `lcd_rs`, `lcd_data`, one bit per `clk` while CS low, MSB first). It deserialises bytes, buffers them in a FIFO for host readback (e.g. UART dump), and tracks the ST7789-style CASET/RASET/RAMWR sequence to emit each written pixel with its (x, y) coordinate. It sits beside the display driver on the same 27 MHz clock as a bus monitor and panel model for the RISC-V monitor design.

## Interface
- `FIFO_DEPTH`, 16: byte FIFO entries; power of two, ≥ 2.
- `COORD_W`, 9: coordinate width; 16-bit parameters are truncated to their low `COORD_W` bits.
- `DEF_X1`, 239: column-end reset value.
- `DEF_Y1`, 319: row-end reset value.

- `clk` in 1: 27 MHz system clock; the LCD bus is synchronous to it.
- `resetn` in 1: asynchronous, active-low reset.
- `lcd_resetn` in 1: panel reset; while low, the decoder and window registers take their reset values. FIFO is unaffected.
- `lcd_cs` / `lcd_rs` / `lcd_data` in 1 each: bus under observation.
- `byte_valid` out 1: FIFO head valid.
- `byte_data` out 8: FIFO head byte.
- `byte_rs` out 1: FIFO head D/C flag (0 = command).
- `byte_ready` in 1: consumer pops the head when high together with `byte_valid`.
- `fifo_overflow` out 1: sticky; cleared only by `resetn`.
- `frame_error` out 1: pulse when CS deasserts with 1–7 bits pending.
- `pix_valid` out 1: pulse, one per completed pixel.
- `pix_data` out 16: RGB565 pixel, first byte in bits [15:8].
- `pix_x`, `pix_y` out `COORD_W`: coordinate of `pix_data`.
- `frame_done` out 1: pulse coincident with the `pix_valid` of the window's last pixel.

## Operation
- **Bit capture:** on each rising `clk` edge with `lcd_cs` = 0, shift `lcd_data` into an 8-bit register and increment a 3-bit counter.
  - On the 8th bit, generate an internal byte strobe with the assembled byte and `lcd_rs` as sampled at that edge.
  - `lcd_cs` = 1 at an edge clears the counter. If the count is non-zero, pulse `frame_error` and discard the partial byte.
- **Multi-byte transfers:** CS held low across bytes continues capture back-to-back, one byte per 8 cycles.
- **FIFO:** every strobe writes {rs, byte}.
  - When full, the write is dropped and `fifo_overflow` is set, unless a pop occurs in the same cycle. In that case both the pop and the write happen.
  - Pop and write in the same cycle on a non-full FIFO both succeed.
- **Decoder states:** IDLE, CASET, RASET, RAMWR, OTHER.
  - Any command byte (rs = 0) leaves the current state immediately and selects the next state: 0x2A → CASET, 0x2B → RASET, 0x2C → RAMWR, anything else → OTHER. A parameter index or pending pixel byte is reset.
  - CASET / RASET: data bytes p0..p3 give start = {p0, p1} and end = {p2, p3}, committed when p3 arrives. Parameters beyond p3 are ignored. An aborted sequence commits nothing.
  - RAMWR: on entry, x = x0 and y = y0.
    - Data bytes pair into pixels (high byte first).
    - After each pixel: if x == x1, then x = x0 and the y rule applies; otherwise x++.
    - y rule: if y == y1, then y = y0 and `frame_done` pulses; otherwise y++.
    - An odd trailing byte is discarded on the next command.
  - OTHER / IDLE: data bytes are ignored by the decoder but still enter the FIFO.
- **Reset values:**
  - All pulses, `byte_valid`, and `fifo_overflow` = 0.
  - `byte_data` = 0, `byte_rs` = 0, `pix_*` = 0.
  - x0 = y0 = 0, x1 = `DEF_X1`, y1 = `DEF_Y1`, state IDLE.

## Timing
- Byte strobe occurs at the edge sampling bit 0 (cycle N).
- FIFO write at edge N+1; `byte_valid` is high after edge N+1 if the FIFO was empty.
- `pix_valid`, `pix_data`, `pix_x`, `pix_y` are registered and high for exactly cycle N+1 after the second pixel byte's strobe.
- Window registers are updated at N+1 after the p3 strobe. A RAMWR arriving 8 cycles later uses the new values.
- Sustained rate is one byte per 8 cycles. The FIFO never overflows if the consumer pops at least once per 8 cycles.
- `resetn` asserted mid-byte or mid-pixel: everything is cleared asynchronously, and capture resumes on the next CS-low bit.

## Structure
- A shared package holds the command opcodes (0x2A, 0x2B, 0x2C), the decoder state encoding, and the reset-default constants.
- Sub-module `sync_fifo`: parameterised width/depth, valid/ready output, full flag. Reusable by the UART path.
- The capture, decoder, and coordinate counters stay in `lcd_spi_monitor`.

## Test plan
- **Command byte:** CS low for 8 cycles, rs = 0, bits of 0x11 → one FIFO entry {0, 0x11}, `byte_valid` high one cycle after the 8th bit. No decoder change.
- **Window setup:** 0x2A 00 28 01 17, then 0x2B 00 35 00 BB, then 0x2C → x0 = 40, x1 = 279 (low 9 bits), y0 = 53, y1 = 187. First pixel is reported at (40, 53).
- **Full frame:** after the setup above, stream 32400 pixels of 0xF800 → last pixel at (279, 187) with `frame_done` high. The next pixel is at (40, 53).
- **Broken transfer:** CS rises after 5 bits → `frame_error` pulse, no FIFO write. The next full byte is captured correctly.
- **Overflow:** `byte_ready` = 0, send 17 bytes with `FIFO_DEPTH` = 16 → 16 entries held, `fifo_overflow` = 1, 17th byte lost. Pop plus write at full keeps the count at 16 without setting the flag.
- **Aborted CASET and panel reset:** 0x2A 00 10 followed by 0x2C → window unchanged. Then drop `lcd_resetn` → x1 = 239, y1 = 319, state IDLE, FIFO contents preserved.

Source files
------------

// File: rtl/lcd_spi_monitor_pkg.sv
// Shared opcodes, decoder state encoding and reset defaults for the LCD bus monitor.
package lcd_spi_monitor_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_COORD_W    = 9;
  localparam int DEF_COL_END    = 239;
  localparam int DEF_ROW_END    = 319;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_CASET,
    DEC_RASET,
    DEC_RAMWR,
    DEC_OTHER
  } dec_state_e;

  function automatic dec_state_e cmd_to_state(input logic [7:0] cmd);
    case (cmd)
      CMD_CASET: return DEC_CASET;
      CMD_RASET: return DEC_RASET;
      CMD_RAMWR: return DEC_RAMWR;
      default:   return DEC_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/lcd_spi_monitor_fifo.sv
// Generic synchronous FIFO with valid/ready head and full flag; a write while
// full is accepted only if the head is popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             rd_ready_i
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign rd_valid_o = (count_q != '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign pop        = rd_valid_o && rd_ready_i;
  assign push       = wr_en_i && (!full_o || pop);
  // Head reads as zero when empty so the outputs have a defined reset value.
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_spi_monitor.sv
// Passive LCD write-bus monitor: bit capture, byte FIFO for host readback, and
// a CASET/RASET/RAMWR decoder that reports every written pixel with its coordinate.
module lcd_spi_monitor
  import lcd_spi_monitor_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int DEF_X1     = DEF_COL_END,
  parameter int DEF_Y1     = DEF_ROW_END
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               lcd_resetn,
  input  logic               lcd_cs,
  input  logic               lcd_rs,
  input  logic               lcd_data,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_rs,
  input  logic               byte_ready,
  output logic               fifo_overflow,
  output logic               frame_error,
  output logic               pix_valid,
  output logic [15:0]        pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_done
);

  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       strobe_q;
  logic [7:0] strobe_byte_q;
  logic       strobe_rs_q;
  logic       frame_error_q;
  logic       overflow_q;
  logic [7:0] byte_d;

  assign byte_d = {shift_q[6:0], lcd_data};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      strobe_q      <= 1'b0;
      strobe_byte_q <= '0;
      strobe_rs_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      strobe_q      <= 1'b0;
      frame_error_q <= 1'b0;
      if (!lcd_cs) begin
        shift_q   <= byte_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          strobe_q      <= 1'b1;
          strobe_byte_q <= byte_d;
          strobe_rs_q   <= lcd_rs;
        end
      end else begin
        bit_cnt_q <= '0;
        if (bit_cnt_q != 3'd0) frame_error_q <= 1'b1;
      end
    end
  end

  logic       fifo_full;
  logic [8:0] fifo_head;

  sync_fifo #(
    .WIDTH(9),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .wr_en_i   (strobe_q),
    .wr_data_i ({strobe_rs_q, strobe_byte_q}),
    .full_o    (fifo_full),
    .rd_valid_o(byte_valid),
    .rd_data_o (fifo_head),
    .rd_ready_i(byte_ready)
  );

  assign byte_rs   = fifo_head[8];
  assign byte_data = fifo_head[7:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (strobe_q && fifo_full && !(byte_valid && byte_ready)) begin
      overflow_q <= 1'b1;
    end
  end

  typedef struct packed {
    dec_state_e         state;
    logic [2:0]         pidx;
    logic [7:0]         p0;
    logic [7:0]         p1;
    logic [7:0]         p2;
    logic [7:0]         hi;
    logic               have_hi;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pix_valid;
    logic               frame_done;
    logic [15:0]        pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
  } dec_t;

  localparam dec_t DEC_RST = '{
    state:   DEC_IDLE,
    x1:      COORD_W'(DEF_X1),
    y1:      COORD_W'(DEF_Y1),
    default: '0
  };

  dec_t               dec_q;
  logic [COORD_W-1:0] par_start, par_end;

  assign par_start = COORD_W'({dec_q.p0, dec_q.p1});
  assign par_end   = COORD_W'({dec_q.p2, strobe_byte_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_q <= DEC_RST;
    end else if (!lcd_resetn) begin
      dec_q <= DEC_RST;
    end else begin
      dec_q.pix_valid  <= 1'b0;
      dec_q.frame_done <= 1'b0;
      if (strobe_q && !strobe_rs_q) begin
        // Any command aborts the current sequence, including a half pixel.
        dec_q.state   <= cmd_to_state(strobe_byte_q);
        dec_q.pidx    <= '0;
        dec_q.have_hi <= 1'b0;
        dec_q.x       <= dec_q.x0;
        dec_q.y       <= dec_q.y0;
      end else if (strobe_q) begin
        case (dec_q.state)
          DEC_CASET, DEC_RASET: begin
            if (dec_q.pidx != 3'd4) dec_q.pidx <= dec_q.pidx + 3'd1;
            case (dec_q.pidx)
              3'd0: dec_q.p0 <= strobe_byte_q;
              3'd1: dec_q.p1 <= strobe_byte_q;
              3'd2: dec_q.p2 <= strobe_byte_q;
              3'd3: begin
                if (dec_q.state == DEC_CASET) begin
                  dec_q.x0 <= par_start;
                  dec_q.x1 <= par_end;
                end else begin
                  dec_q.y0 <= par_start;
                  dec_q.y1 <= par_end;
                end
              end
              default: ;
            endcase
          end
          DEC_RAMWR: begin
            if (!dec_q.have_hi) begin
              dec_q.hi      <= strobe_byte_q;
              dec_q.have_hi <= 1'b1;
            end else begin
              dec_q.have_hi   <= 1'b0;
              dec_q.pix_valid <= 1'b1;
              dec_q.pix_data  <= {dec_q.hi, strobe_byte_q};
              dec_q.pix_x     <= dec_q.x;
              dec_q.pix_y     <= dec_q.y;
              if (dec_q.x == dec_q.x1) begin
                dec_q.x <= dec_q.x0;
                if (dec_q.y == dec_q.y1) begin
                  dec_q.y          <= dec_q.y0;
                  dec_q.frame_done <= 1'b1;
                end else begin
                  dec_q.y <= dec_q.y + COORD_W'(1);
                end
              end else begin
                dec_q.x <= dec_q.x + COORD_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_overflow = overflow_q;
  assign frame_error   = frame_error_q;
  assign pix_valid     = dec_q.pix_valid;
  assign pix_data      = dec_q.pix_data;
  assign pix_x         = dec_q.pix_x;
  assign pix_y         = dec_q.pix_y;
  assign frame_done    = dec_q.frame_done;

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Directed plus randomized bench for lcd_spi_monitor; expectations come from a
// window/pixel-index reference model and a byte queue.
module tb_lcd_spi_monitor;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        lcd_resetn = 1'b1;
  logic        lcd_cs = 1'b1;
  logic        lcd_rs = 1'b0;
  logic        lcd_data = 1'b0;
  logic        byte_ready = 1'b0;
  logic        byte_valid, byte_rs, fifo_overflow, frame_error;
  logic [7:0]  byte_data;
  logic        pix_valid, frame_done;
  logic [15:0] pix_data;
  logic [8:0]  pix_x, pix_y;

  lcd_spi_monitor dut (
    .clk          (clk),
    .resetn       (resetn),
    .lcd_resetn   (lcd_resetn),
    .lcd_cs       (lcd_cs),
    .lcd_rs       (lcd_rs),
    .lcd_data     (lcd_data),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_rs      (byte_rs),
    .byte_ready   (byte_ready),
    .fifo_overflow(fifo_overflow),
    .frame_error  (frame_error),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fd;
    logic [8:0] y;
    logic [8:0] x;
    logic [15:0] d;
  } pix_t;

  pix_t       pix_q[$];
  pix_t       exp_pix[$];
  logic [8:0] pop_q[$];
  logic [8:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int ferr_seen = 0, ferr_exp = 0, stray_fd = 0;

  // Reference model: current command, its parameter bytes, and the window.
  int         m_cmd = -1;
  logic [7:0] m_par[$];
  int mx0 = 0, mx1 = 239, my0 = 0, my1 = 319;

  always @(negedge clk) begin
    if (pix_valid) pix_q.push_back(pix_t'({frame_done, pix_y, pix_x, pix_data}));
    else if (frame_done) stray_fd++;
    if (frame_error) ferr_seen++;
    if (byte_valid && byte_ready) pop_q.push_back({byte_rs, byte_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_panel_reset();
    m_cmd = -1;
    m_par.delete();
    mx0 = 0; mx1 = 239; my0 = 0; my1 = 319;
  endtask

  task automatic model_byte(input logic rs, input logic [7:0] b);
    pix_t p;
    int k, w, h, s, e;
    exp_q.push_back({rs, b});
    if (!rs) begin
      m_cmd = int'(b);
      m_par.delete();
    end else begin
      m_par.push_back(b);
      if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_par.size() == 4) begin
        s = int'({m_par[0], m_par[1]}) % 512;
        e = int'({m_par[2], m_par[3]}) % 512;
        if (m_cmd == 'h2A) begin mx0 = s; mx1 = e; end
        else begin my0 = s; my1 = e; end
      end
      if (m_cmd == 'h2C && (m_par.size() % 2) == 0) begin
        k = m_par.size() / 2 - 1;
        w = mx1 - mx0 + 1;
        h = my1 - my0 + 1;
        p.fd = ((k % (w * h)) == w * h - 1);
        p.x  = 9'(mx0 + k % w);
        p.y  = 9'(my0 + (k / w) % h);
        p.d  = {m_par[2*k], m_par[2*k+1]};
        exp_pix.push_back(p);
      end
    end
  endtask

  task automatic send_bits(input logic rs, input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(posedge clk); #2;
      lcd_cs = 1'b0; lcd_rs = rs; lcd_data = b[i];
    end
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_bits(rs, b, 8);
    model_byte(rs, b);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] par, input int n);
    logic [31:0] v;
    v = par;
    send_byte(1'b0, cmd);
    for (int i = 0; i < n; i++) begin
      send_byte(1'b1, v[31:24]);
      v = v << 8;
    end
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      send_byte(1'b1, d[15:8]);
      send_byte(1'b1, d[7:0]);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #2;
    lcd_cs = 1'b1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    int n;
    idle(3);
    byte_ready = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    check({tag, "_fifo_n"}, 64'(pop_q.size()), 64'(exp_q.size()));
    n = (pop_q.size() < exp_q.size()) ? pop_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_fifo_byte"}, 64'(pop_q[i]), 64'(exp_q[i]));
    check({tag, "_pix_n"}, 64'(pix_q.size()), 64'(exp_pix.size()));
    n = (pix_q.size() < exp_pix.size()) ? pix_q.size() : exp_pix.size();
    for (int i = 0; i < n; i++) check({tag, "_pix"}, 64'(pix_q[i]), 64'(exp_pix[i]));
    pop_q.delete(); exp_q.delete(); pix_q.delete(); exp_pix.delete();
  endtask

  logic [8:0] xs, ys;
  int         w, h, np;
  logic [7:0] b17, b18, rb;
  logic       rrs;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_rs", byte_rs, 1'b0);
    check("rst_overflow", fifo_overflow, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix", {pix_data, pix_x, pix_y, frame_done}, '0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // Single command byte and FIFO write latency
    byte_ready = 1'b0;
    send_byte(1'b0, 8'h11);
    @(posedge clk); #2;
    lcd_cs = 1'b1;
    @(negedge clk);
    check("cmd_valid_at_strobe", byte_valid, 1'b0);
    @(negedge clk);
    check("cmd_valid_next", byte_valid, 1'b1);
    check("cmd_data", byte_data, 8'h11);
    check("cmd_rs", byte_rs, 1'b0);
    drain("cmd");

    // Window setup from the worked example
    send_cmd(8'h2A, 32'h0028_0117, 4);
    send_cmd(8'h2B, 32'h0035_00BB, 4);
    send_cmd(8'h2C, 32'h0, 0);
    send_pixels(3);
    drain("win");

    // Small window ending at (279, 187): frame_done and wrap
    send_cmd(8'h2A, 32'h0114_0117, 4);
    send_cmd(8'h2B, 32'h00B9_00BB, 4);
    send_cmd(8'h2C, 32'h0, 0);
    send_pixels(14);
    drain("frame");

    // Broken transfer
    send_bits(1'b1, 8'hFF, 5);
    idle(3);
    ferr_exp++;
    check("ferr_count", 64'(ferr_seen), 64'(ferr_exp));
    check("ferr_no_write", 64'(pop_q.size()), 64'd0);
    check("ferr_no_valid", byte_valid, 1'b0);
    send_byte(1'b1, 8'hA5);
    send_cmd(8'h00, 32'h0, 0);
    drain("brk");

    // Overflow: fill, pop+write at full, then a dropped write
    byte_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rrs = 1'($urandom);
      rb  = rrs ? 8'($urandom) : 8'($urandom_range(0, 8'h29));
      send_byte(rrs, rb);
    end
    idle(2);
    check("ovf_full_no_flag", fifo_overflow, 1'b0);
    check("ovf_full_valid", byte_valid, 1'b1);
    b17 = 8'($urandom);
    send_bits(1'b1, b17, 8);
    model_byte(1'b1, b17);
    @(posedge clk); #2;
    lcd_cs = 1'b1; byte_ready = 1'b1;
    @(posedge clk); #2;
    byte_ready = 1'b0;
    idle(2);
    check("ovf_popwr_no_flag", fifo_overflow, 1'b0);
    b18 = 8'($urandom);
    send_byte(1'b1, b18);
    void'(exp_q.pop_back());
    idle(2);
    check("ovf_set", fifo_overflow, 1'b1);
    drain("ovf");
    check("ovf_sticky", fifo_overflow, 1'b1);

    // Aborted CASET leaves the window unchanged
    send_cmd(8'h2A, 32'h0010_0000, 2);
    send_cmd(8'h2C, 32'h0, 0);
    send_pixels(2);
    drain("abort");

    // Panel reset restores the default window but keeps the FIFO
    byte_ready = 1'b0;
    send_cmd(8'h3A, 32'h5500_0000, 1);
    send_byte(1'b1, 8'h77);
    idle(2);
    lcd_resetn = 1'b0;
    model_panel_reset();
    repeat (3) @(posedge clk);
    #2;
    lcd_resetn = 1'b1;
    check("panel_rst_fifo_kept", byte_valid, 1'b1);
    byte_ready = 1'b1;
    send_cmd(8'h2C, 32'h0, 0);
    send_pixels(241);
    drain("panel");

    // Randomized windows with truncated high bits and interleaved commands
    for (int it = 0; it < 4; it++) begin
      xs = 9'($urandom_range(0, 400));
      w  = $urandom_range(1, 5);
      ys = 9'($urandom_range(0, 400));
      h  = $urandom_range(1, 4);
      send_cmd(8'h2A, {7'($urandom), xs, 7'($urandom), 9'(xs + 9'(w - 1))}, 4);
      if ($urandom_range(0, 1) == 1) send_byte(1'b1, 8'($urandom));
      send_cmd(8'h36, {8'($urandom), 24'h0}, 1);
      send_cmd(8'h2B, {7'($urandom), ys, 7'($urandom), 9'(ys + 9'(h - 1))}, 4);
      send_cmd(8'h2C, 32'h0, 0);
      np = w * h + $urandom_range(0, 3);
      send_pixels(np);
      if ($urandom_range(0, 1) == 1) send_byte(1'b1, 8'($urandom));
      send_cmd(8'h00, 32'h0, 0);
      drain($sformatf("rnd%0d", it));
    end

    // Asynchronous reset in the middle of a byte
    send_bits(1'b1, 8'h3C, 3);
    #1;
    resetn = 1'b0;
    lcd_cs = 1'b1;
    model_panel_reset();
    #1;
    check("arst_overflow_clr", fifo_overflow, 1'b0);
    check("arst_valid_clr", byte_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    send_byte(1'b1, 8'h5A);
    send_cmd(8'h2C, 32'h0, 0);
    send_pixels(2);
    drain("arst");

    check("ferr_total", 64'(ferr_seen), 64'(ferr_exp));
    check("stray_frame_done", 64'(stray_fd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
